// File: rtl/video_pkg.sv
// Shared pixel/AXI4-Stream types and default video timing for the ray marcher output path.
package video_pkg;

    typedef logic [23:0] rgb24;

    typedef struct packed {
        logic [31:0] tdata;
        logic        tlast;
        logic        tuser;
    } axis_word_t;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } pack_state_e;

    localparam int unsigned H_RES_DEFAULT = 640;
    localparam int unsigned V_RES_DEFAULT = 480;

endpackage

// File: rtl/pixel_stream_packer_if.sv
// Pixel stream in and AXI4-Stream out of the packer; master is the packer, slave is its environment.
interface pixel_stream_packer_if;
    import video_pkg::*;

    logic        s_valid;
    logic        s_ready;
    rgb24        s_data;
    logic        s_sof;
    logic        s_eol;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;

    modport master (
        input  s_valid, s_data, s_sof, s_eol, m_axis_tready,
        output s_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    modport slave (
        output s_valid, s_data, s_sof, s_eol, m_axis_tready,
        input  s_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

endinterface

// File: rtl/axis_out_reg.sv
// Single-entry AXI4-Stream output register; a word holds stable until tready.
module axis_out_reg
    import video_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  axis_word_t word_i,
    input  logic       tready_i,
    output logic       tvalid_o,
    output axis_word_t word_o,
    output logic       free_o
);

    logic       valid_q;
    axis_word_t word_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            word_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            word_q  <= word_i;
        end else if (tready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign free_o   = !valid_q || tready_i;
    assign tvalid_o = valid_q;
    assign word_o   = word_q;

endmodule

// File: rtl/pixel_stream_packer.sv
// Packs 24-bit RGB pixels into little-endian 32-bit AXI4-Stream words (4 pixels -> 3 words)
// with per-line tlast, per-frame tuser, and line length / line count checking.
module pixel_stream_packer
    import video_pkg::*;
#(
    parameter int unsigned H_RES = H_RES_DEFAULT,
    parameter int unsigned V_RES = V_RES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    pixel_stream_packer_if.master bus,
    output logic                  err_line_len,
    output logic                  err_sof,
    output logic                  frame_done
);

    localparam int unsigned XW = $clog2(H_RES + 1);
    localparam int unsigned YW = $clog2(V_RES + 1);
    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [XW-1:0] X_SAT  = XW'(H_RES);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    pack_state_e   state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    rgb24          hold_q, hold_d;
    logic          sof_pend_q, sof_pend_d;
    logic          err_len_q, err_len_d;
    logic          err_sof_q, err_sof_d;
    logic          frame_q, frame_d;

    logic          s_ready, accept, load, out_free, tvalid, sof_any;
    logic [1:0]    ph;
    logic [XW-1:0] xe;
    logic [YW-1:0] ye;
    rgb24          pix;
    axis_word_t    word, out_word;

    assign pix     = bus.s_data;
    assign s_ready = (state_q == ST_RUN) && out_free;
    assign accept  = bus.s_valid && s_ready;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        x_d        = x_q;
        y_d        = y_q;
        hold_d     = hold_q;
        sof_pend_d = sof_pend_q;
        err_len_d  = 1'b0;
        err_sof_d  = 1'b0;
        frame_d    = 1'b0;
        load       = 1'b0;
        word       = '0;
        ph         = bus.s_sof ? 2'd0 : phase_q;
        xe         = bus.s_sof ? '0 : x_q;
        ye         = bus.s_sof ? '0 : y_q;
        sof_any    = bus.s_sof || sof_pend_q;

        unique case (state_q)
            ST_FLUSH: begin
                if (out_free) begin
                    load       = 1'b1;
                    word.tdata = {8'h00, hold_q};
                    word.tlast = 1'b1;
                    word.tuser = sof_pend_q;
                    sof_pend_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            default: begin
                if (accept) begin
                    err_sof_d = bus.s_sof && (x_q != '0 || phase_q != '0);
                    phase_d   = ph + 2'd1;
                    // Leftover bytes are kept right-aligned and zero-extended so the flush word is just {8'h00, hold}.
                    unique case (ph)
                        2'd0: begin
                            hold_d     = pix;
                            load       = bus.s_eol;
                            word.tdata = {8'h00, pix};
                        end
                        2'd1: begin
                            load       = 1'b1;
                            word.tdata = {pix[7:0], hold_q[23:0]};
                            hold_d     = {8'h00, pix[23:8]};
                        end
                        2'd2: begin
                            load       = 1'b1;
                            word.tdata = {pix[15:0], hold_q[15:0]};
                            hold_d     = {16'h0000, pix[23:16]};
                        end
                        default: begin
                            load       = 1'b1;
                            word.tdata = {pix, hold_q[7:0]};
                        end
                    endcase
                    word.tlast = bus.s_eol && (ph == 2'd0 || ph == 2'd3);
                    word.tuser = sof_any;
                    sof_pend_d = load ? 1'b0 : sof_any;

                    if (bus.s_eol) begin
                        phase_d   = 2'd0;
                        x_d       = '0;
                        err_len_d = (xe != X_LAST);
                        if (ph == 2'd1 || ph == 2'd2) state_d = ST_FLUSH;
                        if (ye == Y_LAST) begin
                            frame_d = 1'b1;
                            y_d     = '0;
                        end else begin
                            y_d = ye + 1'b1;
                        end
                    end else begin
                        err_len_d = (xe == X_LAST);
                        x_d       = (xe == X_SAT) ? xe : xe + 1'b1;
                        y_d       = ye;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            phase_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            hold_q     <= '0;
            sof_pend_q <= 1'b0;
            err_len_q  <= 1'b0;
            err_sof_q  <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            x_q        <= x_d;
            y_q        <= y_d;
            hold_q     <= hold_d;
            sof_pend_q <= sof_pend_d;
            err_len_q  <= err_len_d;
            err_sof_q  <= err_sof_d;
            frame_q    <= frame_d;
        end
    end

    axis_out_reg u_out (
        .clk_i   (clk),
        .rst_ni  (rst),
        .load_i  (load),
        .word_i  (word),
        .tready_i(bus.m_axis_tready),
        .tvalid_o(tvalid),
        .word_o  (out_word),
        .free_o  (out_free)
    );

    assign bus.s_ready       = s_ready;
    assign bus.m_axis_tvalid = tvalid;
    assign bus.m_axis_tdata  = out_word.tdata;
    assign bus.m_axis_tlast  = out_word.tlast;
    assign bus.m_axis_tuser  = out_word.tuser;
    assign err_line_len      = err_len_q;
    assign err_sof           = err_sof_q;
    assign frame_done        = frame_q;

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Directed bench for pixel_stream_packer with a small 4x2 frame geometry.
module tb_pixel_stream_packer;
    import video_pkg::*;

    localparam int unsigned HR = 4;
    localparam int unsigned VR = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic err_line_len, err_sof, frame_done;
    int   tready_mode;

    pixel_stream_packer_if bus ();

    pixel_stream_packer #(.H_RES(HR), .V_RES(VR)) dut (
        .clk         (clk),
        .rst         (rst_n),
        .bus         (bus),
        .err_line_len(err_line_len),
        .err_sof     (err_sof),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        case (tready_mode)
            0:       bus.m_axis_tready = 1'b1;
            1:       bus.m_axis_tready = ($urandom_range(0, 1) != 0);
            default: bus.m_axis_tready = 1'b0;
        endcase
    end

    // Monitor: captures transfers, counts pulses and checks that stalled words hold.
    logic [33:0] got_q[$];
    int          n_len = 0, n_sof = 0, n_frame = 0, n_low = 0, n_hold_seen = 0, n_hold_bad = 0;
    logic        prev_stall = 1'b0;
    logic [33:0] prev_word, cur;

    always @(negedge clk) begin
        #2;
        cur = {bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_hold_seen++;
                if (!bus.m_axis_tvalid || cur != prev_word) n_hold_bad++;
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) got_q.push_back(cur);
            if (err_line_len) n_len++;
            if (err_sof) n_sof++;
            if (frame_done) n_frame++;
            if (!bus.s_ready) n_low++;
            prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
            prev_word  = cur;
        end
    end

    logic [33:0] exp_q[$];
    int          base, s_len, s_sof, s_frame, s_low;

    task automatic expect_word(input logic [31:0] d, input logic last, input logic user);
        exp_q.push_back({d, last, user});
    endtask

    task automatic begin_window();
        base    = got_q.size();
        s_len   = n_len;
        s_sof   = n_sof;
        s_frame = n_frame;
        s_low   = n_low;
        exp_q.delete();
    endtask

    task automatic end_window(input string tag, input int e_len, input int e_sof, input int e_frame, input int e_low);
        for (int i = 0; i < 200 && (got_q.size() - base) < exp_q.size(); i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check({tag, "_count"}, 64'(got_q.size() - base), 64'(exp_q.size()));
        foreach (exp_q[i])
            if (base + i < got_q.size()) check($sformatf("%s_w%0d", tag, i), 64'(got_q[base + i]), 64'(exp_q[i]));
        check({tag, "_errlen"}, 64'(n_len - s_len), 64'(e_len));
        check({tag, "_errsof"}, 64'(n_sof - s_sof), 64'(e_sof));
        check({tag, "_frame"}, 64'(n_frame - s_frame), 64'(e_frame));
        if (e_low >= 0) check({tag, "_sready_low"}, 64'(n_low - s_low), 64'(e_low));
    endtask

    task automatic send(input logic [23:0] d, input logic sof, input logic eol);
        int guard = 0;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_sof   = sof;
        bus.s_eol   = eol;
        #1;
        while (!bus.s_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!bus.s_ready) check("accept_wait", 64'(bus.s_ready), 64'd1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        bus.s_eol   = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_tvalid"}, 64'(bus.m_axis_tvalid), 64'd0);
        check({tag, "_tdata"}, 64'(bus.m_axis_tdata), 64'd0);
        check({tag, "_tlast_tuser"}, 64'({bus.m_axis_tlast, bus.m_axis_tuser}), 64'd0);
        check({tag, "_pulses"}, 64'({err_line_len, err_sof, frame_done}), 64'd0);
        check({tag, "_sready"}, 64'(bus.s_ready), 64'd1);
    endtask

    task automatic send_line_b();
        send(24'h112233, 1'b1, 1'b0);
        send(24'h445566, 1'b0, 1'b0);
        send(24'h778899, 1'b0, 1'b0);
        send(24'hAABBCC, 1'b0, 1'b1);
    endtask

    task automatic expect_line_b();
        expect_word(32'h66112233, 1'b0, 1'b1);
        expect_word(32'h88994455, 1'b0, 1'b0);
        expect_word(32'hAABBCC77, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        tready_mode = 0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_sof   = 1'b0;
        bus.s_eol   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Two full lines: sof on the first, frame_done on the second eol.
        begin_window();
        send(24'h112233, 1'b1, 1'b0);
        send(24'h445566, 1'b0, 1'b0);
        #1;
        check("latency_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
        check("latency_tdata", 64'(bus.m_axis_tdata), 64'h66112233);
        check("latency_tuser", 64'(bus.m_axis_tuser), 64'd1);
        send(24'h778899, 1'b0, 1'b0);
        send(24'hAABBCC, 1'b0, 1'b1);
        send(24'h010203, 1'b0, 1'b0);
        send(24'h040506, 1'b0, 1'b0);
        send(24'h070809, 1'b0, 1'b0);
        send(24'h0A0B0C, 1'b0, 1'b1);
        idle();
        expect_line_b();
        expect_word(32'h06010203, 1'b0, 1'b0);
        expect_word(32'h08090405, 1'b0, 1'b0);
        expect_word(32'h0A0B0C07, 1'b1, 1'b0);
        end_window("frame", 0, 0, 1, 0);

        // Short line ending at phase 1: normal word then one flush word.
        begin_window();
        send(24'h111111, 1'b1, 1'b0);
        send(24'h123456, 1'b0, 1'b1);
        idle();
        expect_word(32'h56111111, 1'b0, 1'b1);
        expect_word(32'h00001234, 1'b1, 1'b0);
        end_window("short", 1, 0, 0, 1);

        // Over-long line ending at phase 2, with random back-pressure.
        tready_mode = 1;
        begin_window();
        send(24'hA1A2A3, 1'b0, 1'b0);
        send(24'hB1B2B3, 1'b0, 1'b0);
        send(24'hC1C2C3, 1'b0, 1'b0);
        send(24'hD1D2D3, 1'b0, 1'b0);
        send(24'hE1E2E3, 1'b0, 1'b0);
        send(24'hF1F2F3, 1'b0, 1'b0);
        send(24'h717273, 1'b0, 1'b1);
        idle();
        expect_word(32'hB3A1A2A3, 1'b0, 1'b0);
        expect_word(32'hC2C3B1B2, 1'b0, 1'b0);
        expect_word(32'hD1D2D3C1, 1'b0, 1'b0);
        expect_word(32'hF3E1E2E3, 1'b0, 1'b0);
        expect_word(32'h7273F1F2, 1'b0, 1'b0);
        expect_word(32'h00000071, 1'b1, 1'b0);
        end_window("long", 2, 0, 1, -1);
        tready_mode = 0;

        // sof arriving at x=3: held byte dropped, packing restarts at phase 0.
        begin_window();
        send(24'h101010, 1'b1, 1'b0);
        send(24'h202020, 1'b0, 1'b0);
        send(24'h303030, 1'b0, 1'b0);
        send(24'h404040, 1'b1, 1'b0);
        send(24'h505050, 1'b0, 1'b0);
        send(24'h606060, 1'b0, 1'b0);
        send(24'h707070, 1'b0, 1'b1);
        idle();
        expect_word(32'h20101010, 1'b0, 1'b1);
        expect_word(32'h30302020, 1'b0, 1'b0);
        expect_word(32'h50404040, 1'b0, 1'b1);
        expect_word(32'h60605050, 1'b0, 1'b0);
        expect_word(32'h70707060, 1'b1, 1'b0);
        end_window("sofmid", 0, 1, 0, 0);

        // Asynchronous reset while a word is stalled in the output register.
        tready_mode = 2;
        send(24'h101010, 1'b1, 1'b0);
        send(24'h202020, 1'b0, 1'b0);
        idle();
        repeat (2) @(negedge clk);
        #1;
        check("stall_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
        check("stall_tdata", 64'(bus.m_axis_tdata), 64'h20101010);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        check("async_rst_tdata", 64'(bus.m_axis_tdata), 64'd0);
        check("async_rst_tuser", 64'(bus.m_axis_tuser), 64'd0);
        tready_mode = 0;
        repeat (2) @(negedge clk);
        #1;
        check_quiet("in_reset");
        @(negedge clk);
        rst_n = 1'b1;

        begin_window();
        send_line_b();
        idle();
        expect_line_b();
        end_window("restart", 0, 0, 0, 0);

        check("hold_stable", 64'(n_hold_bad), 64'd0);
        check("hold_seen", 64'(n_hold_seen > 0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_stream_packer.md
Name: pixel_stream_packer

Overview:
- Receiving end of the ray marcher pixel stream (`shade_out`/`valid_out`/`ready_in`/`sof`/`eol`).
- Packs 24-bit RGB pixels into 32-bit AXI4-Stream words for the VDMA: 4 pixels -> 3 words, little-endian byte order.
- Marks the first word of each frame with `tuser` and the last word of each line with `tlast`.
- Checks line length and line count.

Parameters:
- H_RES, 640, pixels per line; checked against `eol`.
- V_RES, 480, lines per frame; used for `frame_done`.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- s_valid  in  1  pixel valid; driven from upstream `valid_out`.
- s_ready  out  1  pixel accepted this cycle when s_valid && s_ready; drives upstream `ready_in`.
- s_data  in  24  pixel RGB.
- s_sof  in  1  first pixel of frame.
- s_eol  in  1  last pixel of line.
- m_axis_tdata  out  32  packed word.
- m_axis_tvalid  out  1  word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last word of line.
- m_axis_tuser  out  1  first word of frame.
- err_line_len  out  1  one-cycle pulse: `eol` at x != H_RES-1, or x reaches H_RES without `eol`.
- err_sof  out  1  one-cycle pulse: `sof` accepted with x != 0 or phase != 0.
- frame_done  out  1  one-cycle pulse: `eol` accepted on line V_RES-1.

Behaviour:
- Reset (rst=0, async) forces the following to 0:
  - all outputs: m_axis_tvalid/tdata/tlast/tuser, err_*, frame_done;
  - internal state: phase, x, y, hold register, sof_pending; state = RUN.
- Reset mid-word discards held bytes and any word in the output register.
- Output register is single entry.
  - s_ready = (state==RUN) && (!m_axis_tvalid || m_axis_tready).
  - Output register loads on the accepting edge.
  - Latency: pixel accepted at edge N appears on m_axis at edge N+1 (when a word is produced).
- Packing by phase p (0..3) of accepted pixel P; H holds leftover bytes:
  - p0: H <= P; no word emitted (tvalid clears if tready).
  - p1: word {P[7:0], H[23:0]}; H <= P[23:8].
  - p2: word {P[15:0], H[15:0]}; H <= P[23:16].
  - p3: word {P[23:0], H[7:0]}; phase wraps to 0.
- `eol` on a pixel forces completion of the line; zero padding goes in the upper bytes.
  - p0: emit {8'h00, P}; tlast=1; phase<=0.
  - p1: emit word as normal (tlast=0), then state FLUSH; next word {16'h0000, P[23:8]} with tlast=1.
  - p2: emit word as normal, then FLUSH word {24'h000000, P[23:16]} with tlast=1.
  - p3: normal word with tlast=1.
- FLUSH state:
  - s_ready=0.
  - Loads the flush word when the output register is free, then returns to RUN.
- Output handshake: a word holds stable (tdata/tlast/tuser) while tvalid && !tready.
- `sof`:
  - Sets sof_pending.
  - tuser=1 on the first word emitted after the sof pixel (including the p0-eol word); then clears sof_pending.
  - sof with x!=0 or phase!=0: pulse err_sof, discard H, reset phase/x/y to 0, treat the pixel as the first pixel.
- Counters:
  - x increments per accepted pixel; on `eol`, x<=0 and y increments.
  - `eol` with y==V_RES-1 pulses frame_done and sets y<=0.
  - `sof` forces y<=0.
- Line length:
  - `eol` at x != H_RES-1 pulses err_line_len; the line is still terminated normally.
  - A pixel accepted at x==H_RES-1 without `eol` pulses err_line_len; x saturates and packing continues.
- Simultaneous `sof`+`eol` (1-pixel line) is legal: one word, tuser=1, tlast=1.

Decomposition:
- Shared package `video_pkg`:
  - typedef rgb24 (logic [23:0]);
  - typedef axis_word_t (tdata/tlast/tuser);
  - constants H_RES_DEFAULT=640, V_RES_DEFAULT=480.
- One natural sub-module: `axis_out_reg`, the single-entry output register with the valid/ready hold rule.

Test Plan:
- Pixels 0x112233, 0x445566, 0x778899, 0xAABBCC (eol on 4th, H_RES=4, sof on 1st), tready=1 -> words 0x66112233 (tuser=1), 0x88994455, 0xAABBCC77 (tlast=1); no errors.
- Full 640x480 frame, tready=1 -> 480 words/line, 230400 words total; tlast every 480th word; one tuser; frame_done once; s_ready low never.
- 5-pixel line, 5th pixel 0xDDEEFF with eol, H_RES=640 -> final word 0x00DDEEFF with tlast; err_line_len pulses once.
- 6-pixel line, eol on 0x123456 at p1 -> word {0x56, p4} then FLUSH word 0x00001234 (tlast=1); s_ready=0 exactly one cycle.
- tready toggled randomly 50% -> words stable while stalled; byte stream identical to the tready=1 run; no pixel lost.
- sof asserted at x=3 mid-line -> err_sof pulse; held bytes discarded; next word has tuser=1. Separately, rst=0 mid-stream -> all outputs 0 asynchronously, and the next sof restarts cleanly.
